round_judge: RTL

Sequential, parametrised answer judge for the mini-game. It arms on a round start and samples N_CHOICE answer keys, detecting press edges. Each press is checked against the system-supplied correct index, and the block emits a registered one-cycle win or lose verdict. It also keeps a saturating score and a win streak, and an optional timeout converts an unanswered round into a loss. It sits between the debounced key inputs and the game controller/display logic.

---
 rtl/round_judge_if.sv | 28 ++
 rtl/round_judge.sv | 120 ++++++++++++
 2 files changed

// File: rtl/round_judge_if.sv
// rtl/round_judge_if.sv - answer-key, round-control and verdict/score signals between game controller and judge
interface round_judge_if #(
  parameter int N_CHOICE = 2,
  parameter int SCORE_W  = 8
);
  localparam int CW = (N_CHOICE > 1) ? $clog2(N_CHOICE) : 1;

  logic                start;
  logic [CW-1:0]       correct_idx;
  logic [N_CHOICE-1:0] keys;
  logic                score_clr;
  logic                busy;
  logic                win;
  logic                lose;
  logic                timeout;
  logic [SCORE_W-1:0]  score;
  logic [SCORE_W-1:0]  streak;

  modport master (
    output start, correct_idx, keys, score_clr,
    input  busy, win, lose, timeout, score, streak
  );

  modport slave (
    input  start, correct_idx, keys, score_clr,
    output busy, win, lose, timeout, score, streak
  );
endinterface

// File: rtl/round_judge.sv
// rtl/round_judge.sv - mini-game answer judge with verdict pulses, saturating score and streak
// Optional round timeout enabled by defining ROUND_JUDGE_TIMEOUT_EN.
module round_judge #(
  parameter int N_CHOICE    = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SCORE_W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  round_judge_if.slave bus
);
  localparam int CW = (N_CHOICE > 1) ? $clog2(N_CHOICE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [N_CHOICE-1:0] key_q;
  logic [N_CHOICE-1:0] pe;
  logic [N_CHOICE-1:0] idx_mask;
  logic [CW-1:0]       idx_q, idx_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;
  logic                to_q, to_d;
  logic [SCORE_W-1:0]  score_q, streak_q;
  logic                win_cond;
  logic                expired;

  assign pe = bus.keys & ~key_q;

  // An out-of-range index shifts the one past the top bit, leaving an empty mask that no press can match.
  assign idx_mask = {{(N_CHOICE-1){1'b0}}, 1'b1} << idx_q;
  // Matching the whole key vector also rejects a press made while another key is still held.
  assign win_cond = (pe != '0) && (bus.keys == idx_mask);

`ifdef ROUND_JUDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state_q != ST_WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d   = bus.correct_idx;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bus.keys == '0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A press always wins over an expiry landing in the same cycle.
        if (pe != '0) begin
          win_d   = win_cond;
          lose_d  = !win_cond;
          state_d = ST_IDLE;
        end else if (expired) begin
          lose_d  = 1'b1;
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= bus.keys;
      idx_q   <= idx_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.score_clr) begin
      score_q  <= '0;
      streak_q <= '0;
    end else if (win_d) begin
      if (score_q != {SCORE_W{1'b1}})  score_q  <= score_q + 1'b1;
      if (streak_q != {SCORE_W{1'b1}}) streak_q <= streak_q + 1'b1;
    end else if (lose_d) begin
      streak_q <= '0;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.win     = win_q;
  assign bus.lose    = lose_q;
  assign bus.timeout = to_q;
  assign bus.score   = score_q;
  assign bus.streak  = streak_q;
endmodule
